// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared encodings and width helpers for the fixed-latency issue controller.
package pipe_issue_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN,
      DONE  = ST_DONE
   } state_t;

   // Credit counter must hold the value FIFO_DEPTH itself.
   function automatic int crd_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int inf_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/pipe_issue_ctrl_valid_pipe_sr.sv
// LATENCY-deep 1-bit valid shift register with synchronous reset; wire when LATENCY==0.
module valid_pipe_sr #(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   generate
      if (LATENCY == 0) begin : g_pass
         assign dout = din;
      end else begin : g_sr
         logic [LATENCY-1:0] vld_pipe;

         // Reset clears every stage so no stale valid escapes after rst.
         always_ff @(posedge clk) begin
            if (rst) vld_pipe <= '0;
            else     vld_pipe <= (vld_pipe << 1) | LATENCY'(din);
         end

         assign dout = vld_pipe[LATENCY-1];
      end
   endgenerate

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issues one job of cfg_len ops into a fixed-latency pipe, gated by result-FIFO credits.
module pipe_issue_ctrl
   import pipe_issue_ctrl_pkg::*;
#(
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16,
   parameter int CRD_W      = crd_width(FIFO_DEPTH),
   parameter int INF_W      = inf_width(LATENCY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             issue,
   output logic             res_valid,
   input  logic             out_pop,
   output logic [CRD_W-1:0] credits,
   output logic [INF_W-1:0] inflight,
   output logic             err
);

   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(FIFO_DEPTH);

   state_t           state;
   logic [LEN_W-1:0] remain;
   logic             pop_ok;

   assign in_ready = (state == RUN) && (credits != '0) && (remain != '0);
   assign issue    = in_valid & in_ready;
   // A pop with nothing reserved is bogus: it is dropped and flagged.
   assign pop_ok   = out_pop && (credits != CRD_FULL);

   valid_pipe_sr #(.LATENCY(LATENCY)) u_vld (
      .clk  (clk),
      .rst  (rst),
      .din  (issue),
      .dout (res_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         remain <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  remain <= cfg_len;
                  busy   <= 1'b1;
                  if (cfg_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  remain <= remain - LEN_W'(1);
                  if (remain == LEN_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (inflight == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Credits persist across jobs; they track the downstream FIFO, not the job.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CRD_FULL;
         err     <= 1'b0;
      end else begin
         case ({issue, pop_ok})
            2'b10:   credits <= credits - CRD_W'(1);
            2'b01:   credits <= credits + CRD_W'(1);
            default: credits <= credits;
         endcase
         if (out_pop && (credits == CRD_FULL)) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         case ({issue, res_valid})
            2'b10:   inflight <= inflight + INF_W'(1);
            2'b01:   inflight <= inflight - INF_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed plus random stimulus checked against a cycle-history reference model.
module tb_pipe_issue_ctrl;

   localparam int LAT   = 4;
   localparam int DEPTH = 8;
   localparam int LEN_W = 16;
   localparam int CRD_W = 4;
   localparam int INF_W = 3;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic             clk = 1'b0;
   logic             rst, start, in_valid, out_pop;
   logic [LEN_W-1:0] cfg_len;
   logic             busy, done, in_ready, issue, res_valid, err;
   logic [CRD_W-1:0] credits;
   logic [INF_W-1:0] inflight;

   always #5 clk = ~clk;

   pipe_issue_ctrl #(
      .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .CRD_W(CRD_W), .INF_W(INF_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
      .issue(issue), .res_valid(res_valid), .out_pop(out_pop),
      .credits(credits), .inflight(inflight), .err(err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_from = 0;
   bit hist [0:16383];
   int m_phase, m_remain, m_cred;
   bit m_err;

   // Ops in flight at cycle c are those issued in cycles c-LAT .. c-1 since the last reset.
   function automatic int win_inflight(input int c);
      int n = 0;
      for (int k = 1; k <= LAT; k++)
         if (c - k >= valid_from && hist[c - k]) n++;
      return n;
   endfunction

   function automatic bit exp_res(input int c);
      return (c - LAT >= valid_from) && hist[c - LAT];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input bit r, input bit s, input int len, input bit iv,
                       input bit pop, input bit do_chk);
      bit e_rdy, e_iss;
      rst = r; start = s; cfg_len = LEN_W'(len); in_valid = iv; out_pop = pop;
      #2;
      e_rdy = (m_phase == P_RUN) && (m_cred != 0) && (m_remain != 0);
      e_iss = iv && e_rdy;
      if (do_chk) begin
         chk("busy",      busy,      (m_phase != P_IDLE));
         chk("done",      done,      (m_phase == P_DONE));
         chk("in_ready",  in_ready,  e_rdy);
         chk("issue",     issue,     e_iss);
         chk("res_valid", res_valid, exp_res(cyc));
         chk("credits",   credits,   m_cred);
         chk("inflight",  inflight,  win_inflight(cyc));
         chk("err",       err,       m_err);
      end
      @(posedge clk);
      hist[cyc] = r ? 1'b0 : e_iss;
      if (r) begin
         m_phase = P_IDLE; m_remain = 0; m_cred = DEPTH; m_err = 1'b0;
         valid_from = cyc + 1;
      end else begin
         if (pop && m_cred == DEPTH) m_err = 1'b1;
         if (pop && m_cred < DEPTH) m_cred++;
         if (e_iss) m_cred--;
         case (m_phase)
            P_IDLE:  if (s) begin
                        m_remain = len;
                        m_phase  = (len == 0) ? P_DONE : P_RUN;
                     end
            P_RUN:   if (e_iss) begin
                        m_remain--;
                        if (m_remain == 0) m_phase = P_DRAIN;
                     end
            P_DRAIN: if (win_inflight(cyc) == 0) m_phase = P_DONE;
            default: m_phase = P_IDLE;
         endcase
      end
      cyc++;
      #1;
   endtask

   initial begin
      m_phase = P_IDLE; m_remain = 0; m_cred = DEPTH; m_err = 1'b0;

      // Reset: state before the first edge is unknown, so only check the second cycle.
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);

      // Basic job of 3 ops, no pops.
      step(0, 1, 3, 1, 0, 1);
      repeat (10) step(0, 0, 0, 1, 0, 1);
      chk("t2_credits_end", credits, 5);
      chk("t2_idle", busy, 0);
      repeat (3) step(0, 0, 0, 0, 1, 1);

      // Credit stall: 10 ops with only 8 credits.
      step(0, 1, 10, 1, 0, 1);
      repeat (12) step(0, 0, 0, 1, 0, 1);
      chk("t3_stall_credits", credits, 0);
      chk("t3_stall_ready", in_ready, 0);
      step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 1, 1);
      repeat (10) step(0, 0, 0, 1, 0, 1);
      chk("t3_credits_end", credits, 0);
      chk("t3_idle", busy, 0);

      // Simultaneous issue+pop at credits==1, and a start during RUN.
      step(0, 0, 0, 0, 1, 1);
      step(0, 1, 3, 1, 0, 1);
      step(0, 1, 7, 1, 1, 1);
      chk("t4_credit_hold", credits, 1);
      repeat (2) step(0, 0, 0, 1, 1, 1);
      repeat (8) step(0, 0, 0, 1, 0, 1);
      chk("t4_idle", busy, 0);
      repeat (7) step(0, 0, 0, 0, 1, 1);

      // Zero-length job.
      step(0, 1, 0, 1, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      chk("t5_credits", credits, DEPTH);

      // Bogus pop, then reset during DRAIN.
      step(0, 0, 0, 0, 1, 1);
      chk("t6_err", err, 1);
      chk("t6_credits_full", credits, DEPTH);
      step(0, 1, 5, 1, 0, 1);
      repeat (6) step(0, 0, 0, 1, 0, 1);
      chk("t6_inflight_before_rst", inflight, 3);
      step(1, 0, 0, 0, 0, 1);
      chk("t6_err_cleared", err, 0);
      chk("t6_credits_rst", credits, DEPTH);
      repeat (8) step(0, 0, 0, 0, 0, 1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bit r, s, iv, pop;
         r   = ($urandom_range(0, 49) == 0);
         s   = ($urandom_range(0, 3) == 0);
         iv  = r ? 1'b0 : ($urandom_range(0, 3) != 0);
         pop = ($urandom_range(0, 2) == 0);
         step(r, s, $urandom_range(0, 12), iv, pop, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
